// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR and trap unit: CSR addresses, op
// encoding, interrupt cause numbers, mstatus fields and mtvec modes.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam int IRQ_EXT        = 11;
   localparam int IRQ_TIMER      = 7;
   localparam int IRQ_LOCAL_BASE = 16;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   // MPP is hardwired to machine mode.
   localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   // Highest-priority pending cause: external, then timer, then lowest local.
   function automatic logic [4:0] irq_cause(input logic [31:0] pend);
      logic [4:0] c;
      c = '0;
      for (int i = 31; i >= IRQ_LOCAL_BASE; i--) begin
         if (pend[i]) c = 5'(i);
      end
      if (pend[IRQ_TIMER]) c = 5'(IRQ_TIMER);
      if (pend[IRQ_EXT])   c = 5'(IRQ_EXT);
      return c;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; a write to
// either half replaces that cycle's increment and leaves the other half alone.
module csr_counter64 (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_inc,
   input  logic        i_we_lo,
   input  logic        i_we_hi,
   input  logic [31:0] i_wdata,
   output logic [63:0] o_count
);

   logic [63:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_we_lo) begin
         r_count <= {r_count[63:32], i_wdata};
      end else if (i_we_hi) begin
         r_count <= {i_wdata, r_count[31:0]};
      end else if (i_inc) begin
         r_count <= r_count + 64'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the MW stage: CSR read/modify/
// write, interrupt sampling and prioritisation, trap entry, mret and counters.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int          NUM_LOCAL = 4,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst,
   input  logic [1:0]                                 i_csr_op,
   input  logic [11:0]                                i_csr_addr,
   input  logic [31:0]                                i_csr_wdata,
   output logic [31:0]                                o_csr_rdata,
   output logic                                       o_illegal_csr,
   input  logic                                       i_instr_valid,
   input  logic [31:0]                                i_instr_pc,
   input  logic                                       i_is_mret,
   input  logic                                       i_irq_ext,
   input  logic                                       i_irq_timer,
   input  logic [((NUM_LOCAL > 0) ? NUM_LOCAL : 1)-1:0] i_irq_local,
   output logic                                       o_redirect,
   output logic [31:0]                                o_redirect_pc
);

   localparam logic [31:0] IRQ_MASK =
      32'h0000_0880 | (((32'h1 << NUM_LOCAL) - 32'h1) << IRQ_LOCAL_BASE);

   logic        r_mstatus_mie;
   logic        r_mstatus_mpie;
   logic [31:0] r_mie;
   logic [31:0] r_mip_q;
   logic [31:0] r_mtvec;
   logic [31:0] r_mscratch;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;

   logic        w_legal;
   logic [31:0] w_old;
   logic [31:0] w_new;
   logic        w_we;
   logic [31:0] w_irq_vec;
   logic [31:0] w_pending;
   logic [4:0]  w_cause;
   logic        w_trap;
   logic        w_mret;
   logic [31:0] w_vec_base;
   logic [63:0] w_mcycle;
   logic [63:0] w_minstret;

   always_comb begin
      w_irq_vec = '0;
      w_irq_vec[IRQ_EXT]   = i_irq_ext;
      w_irq_vec[IRQ_TIMER] = i_irq_timer;
      for (int i = 0; i < NUM_LOCAL; i++) begin
         w_irq_vec[IRQ_LOCAL_BASE + i] = i_irq_local[i];
      end
   end

   always_comb begin
      w_legal = 1'b1;
      w_old   = '0;
      case (i_csr_addr)
         CSR_MSTATUS:   w_old = MSTATUS_MPP_M
                              | (32'(r_mstatus_mpie) << MSTATUS_MPIE)
                              | (32'(r_mstatus_mie) << MSTATUS_MIE);
         CSR_MIE:       w_old = r_mie;
         CSR_MTVEC:     w_old = r_mtvec;
         CSR_MSCRATCH:  w_old = r_mscratch;
         CSR_MEPC:      w_old = r_mepc;
         CSR_MCAUSE:    w_old = r_mcause;
         CSR_MIP:       w_old = r_mip_q;
         CSR_MCYCLE:    w_old = w_mcycle[31:0];
         CSR_MCYCLEH:   w_old = w_mcycle[63:32];
         CSR_MINSTRET:  w_old = w_minstret[31:0];
         CSR_MINSTRETH: w_old = w_minstret[63:32];
         default:       w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_new = w_old;
      case (i_csr_op)
         CSR_RW:  w_new = i_csr_wdata;
         CSR_RS:  w_new = w_old | i_csr_wdata;
         CSR_RC:  w_new = w_old & ~i_csr_wdata;
         default: w_new = w_old;
      endcase
   end

   // i_instr_valid qualifies every MW-stage input: state only changes for a
   // valid instruction, and a trap on that instruction cancels all its effects.
   assign w_pending = r_mip_q & r_mie & {32{r_mstatus_mie}};
   assign w_cause   = irq_cause(w_pending);
   assign w_trap    = (|w_pending) & i_instr_valid;
   assign w_mret    = i_is_mret & i_instr_valid & ~w_trap;

   assign w_we = (i_csr_op != CSR_NONE) & w_legal & i_instr_valid & ~w_trap
               & ~(((i_csr_op == CSR_RS) | (i_csr_op == CSR_RC)) & (i_csr_wdata == '0));

   assign w_vec_base = {r_mtvec[31:2], 2'b00};

   always_comb begin
      o_redirect_pc = r_mepc;
      if (w_trap) begin
         o_redirect_pc = (r_mtvec[1:0] == MTVEC_VECTORED)
                       ? w_vec_base + {25'b0, w_cause, 2'b00}
                       : w_vec_base;
      end
   end

   assign o_redirect    = (w_trap | w_mret) & ~i_rst;
   assign o_illegal_csr = (i_csr_op != CSR_NONE) & ~w_legal;
   assign o_csr_rdata   = w_old;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mip_q        <= '0;
         r_mtvec        <= MTVEC_RST;
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
      end else begin
         r_mip_q <= w_irq_vec;
         if (w_trap) begin
            r_mepc         <= i_instr_pc;
            r_mcause       <= {1'b1, 26'b0, w_cause};
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
         end else if (w_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end
         if (w_we) begin
            case (i_csr_addr)
               CSR_MSTATUS: begin
                  r_mstatus_mie  <= w_new[MSTATUS_MIE];
                  r_mstatus_mpie <= w_new[MSTATUS_MPIE];
               end
               CSR_MIE:      r_mie      <= w_new & IRQ_MASK;
               // Reserved modes 2/3 leave the current mode in place.
               CSR_MTVEC:    r_mtvec    <= {w_new[31:2],
                                            (w_new[1] == 1'b0) ? w_new[1:0] : r_mtvec[1:0]};
               CSR_MSCRATCH: r_mscratch <= w_new;
               CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
               CSR_MCAUSE:   r_mcause   <= w_new;
               default: ;
            endcase
         end
      end
   end

   csr_counter64 u_mcycle (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (1'b1),
      .i_we_lo (w_we & (i_csr_addr == CSR_MCYCLE)),
      .i_we_hi (w_we & (i_csr_addr == CSR_MCYCLEH)),
      .i_wdata (w_new),
      .o_count (w_mcycle)
   );

   csr_counter64 u_minstret (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (i_instr_valid & ~w_trap),
      .i_we_lo (w_we & (i_csr_addr == CSR_MINSTRET)),
      .i_we_hi (w_we & (i_csr_addr == CSR_MINSTRETH)),
      .i_wdata (w_new),
      .o_count (w_minstret)
   );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: a behavioural CSR/trap model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_csr_trap_unit;

   localparam int          NL         = 4;
   localparam logic [31:0] MTVEC_INIT = 32'h0000_0201;
   localparam logic [31:0] IRQ_BITS   = 32'h000F_0880;

   logic          clk;
   logic          rst;
   logic [1:0]    csr_op;
   logic [11:0]   csr_addr;
   logic [31:0]   csr_wdata;
   logic [31:0]   csr_rdata;
   logic          illegal_csr;
   logic          instr_valid;
   logic [31:0]   instr_pc;
   logic          is_mret;
   logic          irq_ext;
   logic          irq_timer;
   logic [NL-1:0] irq_local;
   logic          redirect;
   logic [31:0]   redirect_pc;

   csr_trap_unit #(.NUM_LOCAL(NL), .MTVEC_RST(MTVEC_INIT)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_csr_op      (csr_op),
      .i_csr_addr    (csr_addr),
      .i_csr_wdata   (csr_wdata),
      .o_csr_rdata   (csr_rdata),
      .o_illegal_csr (illegal_csr),
      .i_instr_valid (instr_valid),
      .i_instr_pc    (instr_pc),
      .i_is_mret     (is_mret),
      .i_irq_ext     (irq_ext),
      .i_irq_timer   (irq_timer),
      .i_irq_local   (irq_local),
      .o_redirect    (redirect),
      .o_redirect_pc (redirect_pc)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model state ----------------
   logic        m_mie, m_mpie;
   logic [31:0] m_mie_r, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause;
   logic [63:0] m_cycle, m_instret;

   logic [65:0] exp_q[$];
   int n_cmp, n_fail, n_cyc;

   // stimulus for the next cycle
   logic          s_rst, s_v, s_mret, s_ext, s_tim;
   logic [1:0]    s_op;
   logic [11:0]   s_addr;
   logic [31:0]   s_wd, s_pc;
   logic [NL-1:0] s_loc;

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mip = 0; m_mtvec = MTVEC_INIT;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; m_instret = 0;
   endtask

   function automatic logic m_legal(input logic [11:0] a);
      return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                       12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
         12'h304: return m_mie_r;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return m_mip;
         12'hB00: return m_cycle[31:0];
         12'hB80: return m_cycle[63:32];
         12'hB02: return m_instret[31:0];
         12'hB82: return m_instret[63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic int m_cause(input logic [31:0] pend);
      if (pend[11]) return 11;
      if (pend[7])  return 7;
      for (int i = 0; i < NL; i++) if (pend[16+i]) return 16 + i;
      return 0;
   endfunction

   // ---------------- driver ----------------
   task automatic drive();
      logic        legal, trap, mret_t, we;
      logic [31:0] old, pend, rpc, nv, base;
      logic [63:0] n_cycle, n_instret;
      int          cause;
      rst = s_rst; csr_op = s_op; csr_addr = s_addr; csr_wdata = s_wd;
      instr_valid = s_v; instr_pc = s_pc; is_mret = s_mret;
      irq_ext = s_ext; irq_timer = s_tim; irq_local = s_loc;
      if (s_rst) model_reset();
      legal  = m_legal(s_addr);
      old    = legal ? m_read(s_addr) : 32'h0;
      pend   = m_mie ? (m_mip & m_mie_r) : 32'h0;
      cause  = m_cause(pend);
      trap   = !s_rst && s_v && (pend != 0);
      mret_t = !s_rst && s_v && s_mret && !trap;
      base   = m_mtvec & 32'hFFFF_FFFC;
      rpc    = 32'h0;
      if (trap) rpc = (m_mtvec[1:0] == 2'b01) ? base + 32'(4 * cause) : base;
      else if (mret_t) rpc = m_mepc;
      exp_q.push_back({old, (s_op != 2'b00) && !legal, trap || mret_t, rpc});
      if (!s_rst) begin
         n_cycle   = m_cycle + 64'd1;
         n_instret = m_instret + ((s_v && !trap) ? 64'd1 : 64'd0);
         we = (s_op != 2'b00) && legal && s_v && !trap && !(s_op != 2'b01 && s_wd == 0);
         nv = (s_op == 2'b01) ? s_wd : (s_op == 2'b10) ? (old | s_wd) : (old & ~s_wd);
         if (trap) begin
            m_mepc = s_pc; m_mcause = 32'h8000_0000 + 32'(cause);
            m_mpie = m_mie; m_mie = 0;
         end else if (mret_t) begin
            m_mie = m_mpie; m_mpie = 1;
         end
         m_mip = (s_ext ? 32'h800 : 32'h0) | (s_tim ? 32'h80 : 32'h0) | (32'(s_loc) << 16);
         if (we) begin
            case (s_addr)
               12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h304: m_mie_r = nv & IRQ_BITS;
               12'h305: m_mtvec = (nv[1:0] < 2) ? nv : ((nv & 32'hFFFF_FFFC) | 32'(m_mtvec[1:0]));
               12'h340: m_mscratch = nv;
               12'h341: m_mepc = nv & 32'hFFFF_FFFC;
               12'h342: m_mcause = nv;
               12'hB00: n_cycle = {m_cycle[63:32], nv};
               12'hB80: n_cycle = {nv, m_cycle[31:0]};
               12'hB02: n_instret = {m_instret[63:32], nv};
               12'hB82: n_instret = {nv, m_instret[31:0]};
               default: ;
            endcase
         end
         m_cycle = n_cycle; m_instret = n_instret;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      s_op = 2'b00; s_v = 0; s_mret = 0;
      repeat (n) drive();
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
      s_op = op; s_addr = a; s_wd = wd; s_v = 1; s_mret = 0;
      drive();
      s_op = 2'b00; s_v = 0;
   endtask

   task automatic instr(input logic [31:0] pc, input logic mr);
      s_op = 2'b00; s_v = 1; s_pc = pc; s_mret = mr;
      drive();
      s_v = 0; s_mret = 0;
   endtask

   // ---------------- scoreboard monitor ----------------
   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cycle %0d %s: got %h expected %h", n_cyc, name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      logic [65:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cyc++;
         chk("csr_rdata", csr_rdata, e[65:34]);
         chk("illegal_csr", 32'(illegal_csr), 32'(e[33]));
         chk("redirect", 32'(redirect), 32'(e[32]));
         if (e[32]) chk("redirect_pc", redirect_pc, e[31:0]);
      end
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [11:0] addrs [13];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301};
      n_cmp = 0; n_fail = 0; n_cyc = 0;
      s_rst = 1; s_op = 2'b00; s_addr = 12'h300; s_wd = 0; s_v = 0; s_pc = 0;
      s_mret = 0; s_ext = 0; s_tim = 0; s_loc = '0;
      rst = 1; csr_op = 0; csr_addr = 12'h300; csr_wdata = 0; instr_valid = 0;
      instr_pc = 0; is_mret = 0; irq_ext = 0; irq_timer = 0; irq_local = '0;
      model_reset();
      @(posedge clk); #1;

      // held in reset with a retiring mret presented: no redirect allowed
      s_v = 1; s_mret = 1; s_pc = 32'h10;
      repeat (3) drive();
      s_rst = 0;
      idle(9);
      csr(2'b10, 12'hB00, 32'h0);

      // direct-mode timer trap and mret back
      csr(2'b01, 12'h305, 32'h100);
      csr(2'b01, 12'h304, 32'h80);
      csr(2'b10, 12'h300, 32'h8);
      s_tim = 1; idle(1);
      instr(32'h40, 0);
      s_tim = 0;
      csr(2'b10, 12'h341, 32'h0);
      csr(2'b10, 12'h342, 32'h0);
      csr(2'b10, 12'h300, 32'h0);
      instr(32'h104, 1);
      csr(2'b10, 12'h300, 32'h0);

      // vectored: external beats local0
      csr(2'b01, 12'h305, 32'h101);
      csr(2'b01, 12'h304, 32'h0001_0880);
      s_ext = 1; s_loc = 4'b0001; idle(1);
      instr(32'h80, 0);
      s_ext = 0; s_loc = '0;
      csr(2'b10, 12'h342, 32'h0);
      // mret coincident with an enabled pending timer: trap wins
      s_tim = 1;
      csr(2'b10, 12'h300, 32'h8);
      instr(32'h200, 1);
      s_tim = 0;
      csr(2'b10, 12'h341, 32'h0);
      idle(1);
      instr(32'h13C, 1);

      // counter half writes and carry
      csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
      idle(1);
      csr(2'b10, 12'hB00, 32'h0);
      csr(2'b10, 12'hB80, 32'h0);
      csr(2'b01, 12'hB02, 32'hFFFF_FFFF);
      instr(32'h300, 0);
      csr(2'b10, 12'hB02, 32'h0);
      csr(2'b10, 12'hB82, 32'h0);

      // illegal address, mepc alignment, reserved mtvec mode, mscratch
      csr(2'b01, 12'h340, 32'hA5A5_5A5A);
      csr(2'b01, 12'h7C0, 32'hDEAD_BEEF);
      csr(2'b10, 12'h340, 32'h0);
      csr(2'b01, 12'h341, 32'h0000_0123);
      csr(2'b10, 12'h341, 32'h0);
      csr(2'b01, 12'h305, 32'h0000_0302);
      csr(2'b10, 12'h305, 32'h0);
      csr(2'b11, 12'h304, 32'h0);
      csr(2'b01, 12'h344, 32'hFFFF_FFFF);
      csr(2'b10, 12'h344, 32'h0);

      // clearing MIE masks a pending enabled interrupt
      csr(2'b01, 12'h304, 32'h80);
      s_tim = 1;
      csr(2'b11, 12'h300, 32'h8);
      instr(32'h300, 0);
      csr(2'b10, 12'h344, 32'h0);

      // reset right after a trap
      csr(2'b10, 12'h300, 32'h8);
      instr(32'h400, 0);
      s_rst = 1; s_tim = 0;
      idle(2);
      s_rst = 0;
      idle(1);
      csr(2'b10, 12'h300, 32'h0);
      csr(2'b10, 12'h341, 32'h0);
      csr(2'b10, 12'h342, 32'h0);
      csr(2'b10, 12'h305, 32'h0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         s_rst  = ($urandom_range(0, 399) == 0);
         s_op   = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
         s_addr = addrs[$urandom_range(0, 12)];
         s_wd   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         s_v    = ($urandom_range(0, 9) < 7);
         s_mret = (s_op == 2'b00) && ($urandom_range(0, 15) == 0);
         s_pc   = $urandom & 32'hFFFF_FFFC;
         s_ext  = ($urandom_range(0, 9) == 0);
         s_tim  = ($urandom_range(0, 9) == 0);
         s_loc  = ($urandom_range(0, 3) == 0) ? NL'($urandom_range(0, 15)) : '0;
         drive();
      end
      s_rst = 0; s_ext = 0; s_tim = 0; s_loc = '0;
      idle(2);

      @(negedge clk); #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
